noc_local_port: RTL and testbench
=================================

# noc_local_port

Router-side endpoint of the DMA link: the local port that the DMA's router interface attaches to. It accepts packets the DMA transmits (`rx`/`data_i`/`credit_o`) and forwards them to the mesh. It also buffers packets arriving from the mesh and presents them to the DMA receiver (`tx`/`data_o`/`credit_i`). Both directions are flit FIFOs with credit flow control and a packet-framing tracker (header, size, payload) for packet counting and overflow detection.

## Interface
- `FLIT_WIDTH`, 32: flit and data width.
- `BUFFER_DEPTH`, 8: per-direction FIFO depth, power of two, ≥4.
- `clock`  in  1  single clock; one clock, all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  DMA flit valid, ingress.
- `data_i`  in  FLIT_WIDTH  DMA flit data, ingress.
- `credit_o`  out  1  ingress space available to DMA.
- `tx`  out  1  flit valid to DMA, egress.
- `data_o`  out  FLIT_WIDTH  flit data to DMA.
- `credit_i`  in  1  DMA accepts current egress flit.
- `net_tx_o`  out  1  flit valid toward mesh.
- `net_data_o`  out  FLIT_WIDTH  flit data toward mesh.
- `net_credit_i`  in  1  mesh accepts current flit.
- `net_rx_i`  in  1  flit valid from mesh.
- `net_data_i`  in  FLIT_WIDTH  flit data from mesh.
- `net_credit_o`  out  1  egress space available to mesh.
- `in_pkt_count`  out  16  completed packets pushed from DMA, wraps.
- `out_pkt_count`  out  16  completed packets delivered to DMA, wraps.
- `overflow`  out  1  sticky: a push was dropped because a FIFO was full.

## Operation
- Ingress path (DMA to mesh):
  - Push when `rx`=1.
  - `credit_o` = occupancy < BUFFER_DEPTH-1. This keeps one slot of slack because the DMA registers `rx` one cycle after it samples `credit_o`.
  - `net_tx_o` = not empty. `net_data_o` = FIFO head.
  - Pop when `net_tx_o && net_credit_i`.
- Egress path (mesh to DMA):
  - Push when `net_rx_i`=1.
  - `net_credit_o` = occupancy < BUFFER_DEPTH-1.
  - `tx` = not empty. `data_o` = head.
  - Pop when `tx && credit_i`.
  - The head is held stable while `tx`=1 and `credit_i`=0.
- Push and pop in the same cycle: both take effect and occupancy is unchanged. A push to an empty FIFO appears at the head on the next cycle.
- A push while full is dropped: occupancy and contents are unchanged and `overflow` is set until reset.
- A framing tracker per direction, clocked on that direction's accepted flit (ingress on push, egress on pop):
  - PKT_HEADER: next flit → PKT_SIZE.
  - PKT_SIZE: latch flit as remaining count N (unsigned FLIT_WIDTH). If N=0, increment the packet counter and go to PKT_HEADER. Otherwise go to PKT_PAYLOAD.
  - PKT_PAYLOAD: decrement N on each flit. On the flit where N=1, increment the packet counter and go to PKT_HEADER.
  - Dropped flits do not advance the tracker.
- Packet counters are 16-bit and wrap 0xFFFF → 0x0000.

## Timing
- Reset (synchronous): FIFOs emptied, trackers set to PKT_HEADER, counters 0, `overflow` 0.
- Outputs while `reset`=1: `credit_o`=0, `net_credit_o`=0, `tx`=0, `net_tx_o`=0.
- In the first cycle after reset: `credit_o`=1, `net_credit_o`=1, `tx`=0, `net_tx_o`=0.
- `data_o` and `net_data_o` are don't-care while the matching valid is 0.
- Latency: a flit pushed at edge k is visible at the opposite side at edge k+1. Throughput is one flit per cycle per direction.
- Credits and valids are combinational from registered occupancy. No input reaches an output combinationally.
- Reset mid-packet discards buffered flits and partial framing. Counters do not count the aborted packet.
- The two directions are fully independent. Simultaneous activity on all four sides is legal.

## Structure
- In `orca_pkg`: `pkt_state_t` enum (PKT_HEADER, PKT_SIZE, PKT_PAYLOAD).
- One sub-module, `flit_fifo` (params FLIT_WIDTH, BUFFER_DEPTH; ports: push, push_data, pop, head, empty, almost_full, drop). It is instantiated once per direction.
- The framing tracker is an always block in the top, instantiated twice via a generate loop or duplicated.

## Test plan
- Ingress packet: header 0x11, size 3, payload A,B,C with `net_credit_i`=1 → the same 5 flits on `net_data_o` in order, one cycle after each push; `in_pkt_count`=1.
- Ingress backpressure: `net_credit_i`=0 and push 7 flits (depth 8) → `credit_o` drops when occupancy reaches 7. A forced 9th push sets `overflow`=1 and does not corrupt the stored flits.
- Egress to DMA: mesh pushes header 0x22, size 2, D,E while `credit_i` pulses every third cycle → `data_o` holds each flit until accepted; `out_pkt_count`=1 after E.
- Zero-length packet: header, size 0 → counter increments on the size flit; the next flit is parsed as a header.
- Simultaneous push and pop at occupancy 4 for 10 cycles → occupancy stays 4 and flit order is preserved in both directions.
- Reset after 2 payload flits of a size-5 packet → counters 0, both FIFOs empty, `credit_o`=1 on the next cycle, and a fresh packet parses correctly.

Source files
------------

// File: rtl/orca_pkg.sv
// orca_pkg: shared types for the NoC local port
package orca_pkg;
  typedef enum logic [1:0] {PKT_HEADER, PKT_SIZE, PKT_PAYLOAD} pkt_state_t;
  localparam int PKT_CNT_WIDTH = 16;
endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: circular flit buffer; pushes while full are dropped and flagged
module flit_fifo #(
  parameter int FLIT_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [FLIT_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [FLIT_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  drop
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  logic [FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic full, acc, pop_ok;
  assign full = cnt == (AW+1)'(BUFFER_DEPTH);
  assign acc = push && !full;
  assign pop_ok = pop && !empty;
  assign drop = push && full;
  assign empty = cnt == '0;
  assign almost_full = cnt >= (AW+1)'(BUFFER_DEPTH - 1);
  assign head = mem[rd];
  always_ff @(posedge clock) begin
    if (acc) mem[wr] <= push_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      wr <= acc ? wr + 1'b1 : wr;
      rd <= pop_ok ? rd + 1'b1 : rd;
      cnt <= cnt + (AW+1)'(acc) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/noc_local_port.sv
// noc_local_port: credit-flow DMA<->mesh local port with packet framing trackers
module noc_local_port
  import orca_pkg::*;
#(
  parameter int FLIT_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx,
  input  logic [FLIT_WIDTH-1:0]    data_i,
  output logic                     credit_o,
  output logic                     tx,
  output logic [FLIT_WIDTH-1:0]    data_o,
  input  logic                     credit_i,
  output logic                     net_tx_o,
  output logic [FLIT_WIDTH-1:0]    net_data_o,
  input  logic                     net_credit_i,
  input  logic                     net_rx_i,
  input  logic [FLIT_WIDTH-1:0]    net_data_i,
  output logic                     net_credit_o,
  output logic [PKT_CNT_WIDTH-1:0] in_pkt_count,
  output logic [PKT_CNT_WIDTH-1:0] out_pkt_count,
  output logic                     overflow
);
  logic empty_in, empty_eg, af_in, af_eg, drop_in, drop_eg;
  logic [1:0] adv;
  logic [1:0][FLIT_WIDTH-1:0] flit;
  logic [1:0][PKT_CNT_WIDTH-1:0] pkt_cnt;
  flit_fifo #(.FLIT_WIDTH(FLIT_WIDTH), .BUFFER_DEPTH(BUFFER_DEPTH)) u_ingress (
    .clock(clock), .reset(reset), .push(rx), .push_data(data_i),
    .pop(net_tx_o && net_credit_i), .head(net_data_o), .empty(empty_in),
    .almost_full(af_in), .drop(drop_in)
  );
  flit_fifo #(.FLIT_WIDTH(FLIT_WIDTH), .BUFFER_DEPTH(BUFFER_DEPTH)) u_egress (
    .clock(clock), .reset(reset), .push(net_rx_i), .push_data(net_data_i),
    .pop(tx && credit_i), .head(data_o), .empty(empty_eg),
    .almost_full(af_eg), .drop(drop_eg)
  );
  // one slot of slack covers the DMA's registered response to credit
  assign credit_o = !reset && !af_in;
  assign net_credit_o = !reset && !af_eg;
  assign net_tx_o = !reset && !empty_in;
  assign tx = !reset && !empty_eg;
  assign adv[0] = rx && !drop_in;
  assign flit[0] = data_i;
  assign adv[1] = tx && credit_i;
  assign flit[1] = data_o;
  assign in_pkt_count = pkt_cnt[0];
  assign out_pkt_count = pkt_cnt[1];
  always_ff @(posedge clock) begin
    if (reset) overflow <= 1'b0;
    else overflow <= overflow | drop_in | drop_eg;
  end
  genvar i;
  for (i = 0; i < 2; i++) begin : g_trk
    pkt_state_t st, st_n;
    logic [FLIT_WIDTH-1:0] rem, rem_n;
    logic [PKT_CNT_WIDTH-1:0] cnt, cnt_n;
    logic done, last, zero;
    always_ff @(posedge clock) begin
      if (reset) begin
        st <= PKT_HEADER;
        rem <= '0;
        cnt <= '0;
      end else begin
        st <= st_n;
        rem <= rem_n;
        cnt <= cnt_n;
      end
    end
    always_comb begin
      zero = flit[i] == '0;
      last = rem == FLIT_WIDTH'(1);
      done = adv[i] && ((st == PKT_SIZE && zero) || (st == PKT_PAYLOAD && last));
      st_n = !adv[i] ? st :
             st == PKT_HEADER ? PKT_SIZE :
             st == PKT_SIZE ? (zero ? PKT_HEADER : PKT_PAYLOAD) :
             (last ? PKT_HEADER : PKT_PAYLOAD);
      rem_n = !adv[i] ? rem :
              st == PKT_SIZE ? flit[i] :
              st == PKT_PAYLOAD ? rem - FLIT_WIDTH'(1) : rem;
      cnt_n = cnt + PKT_CNT_WIDTH'(done);
    end
    assign pkt_cnt[i] = cnt;
  end
endmodule

// File: tb/tb_noc_local_port.sv
// tb_noc_local_port: directed and random checks against a queue-based model
module tb_noc_local_port;
  logic clock = 0, reset = 0;
  logic rx = 0, credit_i = 0, net_credit_i = 0, net_rx_i = 0;
  logic [31:0] data_i = 0, net_data_i = 0;
  logic credit_o, tx, net_tx_o, net_credit_o, overflow;
  logic [31:0] data_o, net_data_o;
  logic [15:0] in_pkt_count, out_pkt_count;
  int total = 0, bad = 0;
  logic [31:0] qi[$], qe[$], si[$], se[$];
  bit m_ovf = 0;

  noc_local_port #(.FLIT_WIDTH(32), .BUFFER_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .rx(rx), .data_i(data_i), .credit_o(credit_o),
    .tx(tx), .data_o(data_o), .credit_i(credit_i), .net_tx_o(net_tx_o),
    .net_data_o(net_data_o), .net_credit_i(net_credit_i), .net_rx_i(net_rx_i),
    .net_data_i(net_data_i), .net_credit_o(net_credit_o), .in_pkt_count(in_pkt_count),
    .out_pkt_count(out_pkt_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // packets completed in a flit stream: header, size N, then N payload flits
  function automatic logic [15:0] pkts(input logic [31:0] s[$]);
    longint i = 0;
    logic [15:0] c = 0;
    while (i + 1 < longint'(s.size())) begin
      if (i + 2 + longint'(s[i+1]) <= longint'(s.size())) c++;
      i += 2 + longint'(s[i+1]);
    end
    return c;
  endfunction

  task automatic step();
    int ni, ne;
    bit ip, ia, ep, ea;
    @(posedge clock);
    if (reset) begin
      qi.delete(); qe.delete(); si.delete(); se.delete(); m_ovf = 0;
    end else begin
      ni = qi.size(); ne = qe.size();
      ip = ni > 0 && net_credit_i; ia = rx && ni < 8;
      ep = ne > 0 && credit_i; ea = net_rx_i && ne < 8;
      if ((rx && !ia) || (net_rx_i && !ea)) m_ovf = 1;
      if (ip) void'(qi.pop_front());
      if (ia) begin qi.push_back(data_i); si.push_back(data_i); end
      if (ep) se.push_back(qe.pop_front());
      if (ea) qe.push_back(net_data_i);
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    rx = 0; net_rx_i = 0; credit_i = 0; net_credit_i = 0; data_i = 0; net_data_i = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1; step(); step(); reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; step();
    total++; if ({credit_o, net_credit_o, tx, net_tx_o} !== 4'b0000) begin bad++;
      $display("FAIL reset_outputs: got %b want 0000", {credit_o, net_credit_o, tx, net_tx_o}); end
    reset = 0; #1;
    total++; if ({credit_o, net_credit_o, tx, net_tx_o} !== 4'b1100) begin bad++;
      $display("FAIL post_reset_outputs: got %b want 1100", {credit_o, net_credit_o, tx, net_tx_o}); end
    total++; if ({in_pkt_count, out_pkt_count, overflow} !== 33'd0) begin bad++;
      $display("FAIL post_reset_state: got %h/%h/%b want 0/0/0", in_pkt_count, out_pkt_count, overflow); end
    @(negedge clock);
  endtask

  task automatic test_ingress_packet();
    logic [31:0] f[5] = '{32'h11, 32'd3, 32'hA, 32'hB, 32'hC};
    apply_reset();
    net_credit_i = 1;
    for (int k = 0; k < 5; k++) begin
      rx = 1; data_i = f[k]; step();
      total++; if (net_tx_o !== 1'b1 || net_data_o !== f[k]) begin bad++;
        $display("FAIL ingress_flit%0d: got v=%b d=%h want v=1 d=%h", k, net_tx_o, net_data_o, f[k]); end
    end
    rx = 0; step();
    total++; if (net_tx_o !== 1'b0 || in_pkt_count !== 16'd1) begin bad++;
      $display("FAIL ingress_done: got v=%b cnt=%0d want v=0 cnt=1", net_tx_o, in_pkt_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] f[9] = '{32'h33, 32'd5, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h44, 32'h55};
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      rx = 1; data_i = f[k]; step();
      total++; if (credit_o !== (k + 1 < 7)) begin bad++;
        $display("FAIL bp_credit%0d: got %b want %b", k, credit_o, (k + 1 < 7)); end
    end
    rx = 0;
    total++; if (overflow !== 1'b1) begin bad++;
      $display("FAIL bp_overflow: got %b want 1", overflow); end
    net_credit_i = 1;
    for (int k = 0; k < 8; k++) begin
      total++; if (net_tx_o !== 1'b1 || net_data_o !== f[k]) begin bad++;
        $display("FAIL bp_drain%0d: got v=%b d=%h want v=1 d=%h", k, net_tx_o, net_data_o, f[k]); end
      step();
    end
    total++; if (net_tx_o !== 1'b0 || in_pkt_count !== 16'd1 || overflow !== 1'b1) begin bad++;
      $display("FAIL bp_end: got v=%b cnt=%0d ovf=%b want 0/1/1", net_tx_o, in_pkt_count, overflow); end
  endtask

  task automatic test_egress();
    logic [31:0] g[4] = '{32'h22, 32'd2, 32'hD, 32'hE};
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      net_rx_i = c < 4; net_data_i = c < 4 ? g[c] : 32'h0; credit_i = (c % 3 == 2);
      step();
      total++; if (tx !== (qe.size() > 0) || (qe.size() > 0 && data_o !== qe[0])) begin bad++;
        $display("FAIL egress_c%0d: got v=%b d=%h want v=%b d=%h", c, tx, data_o, qe.size() > 0,
                 qe.size() > 0 ? qe[0] : 32'h0); end
    end
    total++; if (out_pkt_count !== 16'd1 || tx !== 1'b0) begin bad++;
      $display("FAIL egress_done: got cnt=%0d v=%b want 1/0", out_pkt_count, tx); end
  endtask

  task automatic test_zero_len();
    logic [31:0] f[5] = '{32'h66, 32'd0, 32'h77, 32'd1, 32'h9};
    logic [15:0] e[5] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
    apply_reset();
    net_credit_i = 1; credit_i = 1;
    for (int k = 0; k < 5; k++) begin
      rx = 1; data_i = f[k]; net_rx_i = 1; net_data_i = f[k]; step();
      total++; if (in_pkt_count !== e[k]) begin bad++;
        $display("FAIL zero_in%0d: got %0d want %0d", k, in_pkt_count, e[k]); end
    end
    rx = 0; net_rx_i = 0; step(); step();
    total++; if (out_pkt_count !== 16'd2) begin bad++;
      $display("FAIL zero_out: got %0d want 2", out_pkt_count); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      rx = 1; data_i = $urandom; net_rx_i = 1; net_data_i = $urandom; step();
    end
    rx = 1; net_rx_i = 1; net_credit_i = 1; credit_i = 1;
    for (int k = 0; k < 10; k++) begin
      data_i = $urandom; net_data_i = $urandom; step();
      total++; if (credit_o !== 1'b1 || net_credit_o !== 1'b1 || qi.size() != 4 || qe.size() != 4) begin bad++;
        $display("FAIL simul_credit%0d: got %b%b want 11", k, credit_o, net_credit_o); end
      total++; if (net_tx_o !== 1'b1 || net_data_o !== qi[0] || tx !== 1'b1 || data_o !== qe[0]) begin bad++;
        $display("FAIL simul_head%0d: got %h/%h want %h/%h", k, net_data_o, data_o, qi[0], qe[0]); end
    end
    rx = 0; net_rx_i = 0;
    for (int k = 0; k < 4; k++) begin
      total++; if (net_data_o !== qi[0] || data_o !== qe[0]) begin bad++;
        $display("FAIL simul_drain%0d: got %h/%h want %h/%h", k, net_data_o, data_o, qi[0], qe[0]); end
      step();
    end
    total++; if (net_tx_o !== 1'b0 || tx !== 1'b0) begin bad++;
      $display("FAIL simul_empty: got %b%b want 00", net_tx_o, tx); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] f[4] = '{32'h88, 32'd5, 32'h1, 32'h2};
    apply_reset();
    credit_i = 1;
    for (int k = 0; k < 4; k++) begin
      rx = 1; data_i = f[k]; net_rx_i = 1; net_data_i = f[k]; step();
    end
    idle_inputs(); reset = 1; step();
    total++; if ({credit_o, net_credit_o, tx, net_tx_o} !== 4'b0000) begin bad++;
      $display("FAIL mid_reset_outputs: got %b want 0000", {credit_o, net_credit_o, tx, net_tx_o}); end
    reset = 0; #1;
    total++; if ({credit_o, net_credit_o, tx, net_tx_o} !== 4'b1100 || in_pkt_count !== 0 || out_pkt_count !== 0) begin bad++;
      $display("FAIL mid_after: got %b cnt=%0d/%0d want 1100 0/0", {credit_o, net_credit_o, tx, net_tx_o},
               in_pkt_count, out_pkt_count); end
    @(negedge clock);
    net_credit_i = 1; credit_i = 1;
    for (int k = 0; k < 3; k++) begin
      rx = 1; net_rx_i = 1; data_i = k == 1 ? 32'd1 : 32'h5A; net_data_i = data_i; step();
    end
    rx = 0; net_rx_i = 0; step(); step();
    total++; if (in_pkt_count !== 16'd1 || out_pkt_count !== 16'd1) begin bad++;
      $display("FAIL mid_fresh: got %0d/%0d want 1/1", in_pkt_count, out_pkt_count); end
  endtask

  task automatic test_random();
    logic [31:0] gi[$], ge[$];
    int n;
    apply_reset();
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(0, 3); gi.push_back($urandom); gi.push_back(n);
      for (int j = 0; j < n; j++) gi.push_back($urandom);
      n = $urandom_range(0, 3); ge.push_back($urandom); ge.push_back(n);
      for (int j = 0; j < n; j++) ge.push_back($urandom);
    end
    for (int c = 0; c < 500; c++) begin
      rx = credit_o && gi.size() > 0 && ($urandom % 4 != 0);
      data_i = rx ? gi.pop_front() : $urandom;
      net_rx_i = net_credit_o && ge.size() > 0 && ($urandom % 4 != 0);
      net_data_i = net_rx_i ? ge.pop_front() : $urandom;
      net_credit_i = $urandom % 3 != 0; credit_i = $urandom % 2 == 0;
      step();
      total++; if (credit_o !== (qi.size() < 7) || net_credit_o !== (qe.size() < 7)) begin bad++;
        $display("FAIL rnd_credit%0d: got %b%b want %b%b", c, credit_o, net_credit_o, qi.size() < 7, qe.size() < 7); end
      total++; if (net_tx_o !== (qi.size() > 0) || (qi.size() > 0 && net_data_o !== qi[0])) begin bad++;
        $display("FAIL rnd_ingress%0d: got v=%b d=%h", c, net_tx_o, net_data_o); end
      total++; if (tx !== (qe.size() > 0) || (qe.size() > 0 && data_o !== qe[0])) begin bad++;
        $display("FAIL rnd_egress%0d: got v=%b d=%h", c, tx, data_o); end
      total++; if (in_pkt_count !== pkts(si) || out_pkt_count !== pkts(se) || overflow !== m_ovf) begin bad++;
        $display("FAIL rnd_count%0d: got %0d/%0d/%b want %0d/%0d/%b", c, in_pkt_count, out_pkt_count, overflow,
                 pkts(si), pkts(se), m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_ingress_packet();
    test_backpressure();
    test_egress();
    test_zero_len();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
